// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side byte buffer placed directly after the UART receiver. Each rising
// edge of the receiver's done level writes one byte into a first-word-fall-through
// FIFO. The host drains the FIFO through a valid/ready handshake. Bytes that
// arrive while the FIFO is full are dropped and latch a sticky overflow flag.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-low reset
//   rx_done   in   receiver done level (high for many cycles per byte)
//   rx_data   in   receiver byte, stable while rx_done is high
//   rd_ready  in   consumer takes the head entry this cycle
//   clr_ovf   in   clears the sticky overflow flag
//   rd_valid  out  head entry available
//   rd_data   out  head entry, 0 when rd_valid is 0
//   count     out  occupied entries, 0..DEPTH
//   full      out  count == DEPTH
//   empty     out  count == 0
//   overflow  out  sticky, a byte was dropped because the FIFO was full
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_done,
  input  logic [WIDTH-1:0]           rx_data,
  input  logic                       rd_ready,
  input  logic                       clr_ovf,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_done_q;
  logic             r_overflow;

  logic w_wr_req;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_wr_ok;
  logic w_drop;

  // One write per byte regardless of how long done stays high.
  assign w_wr_req = rx_done & ~r_done_q;
  assign w_full   = (r_count == DEPTH_C);
  assign w_empty  = (r_count == '0);
  assign w_pop    = ~w_empty & rd_ready;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign w_wr_ok  = w_wr_req & (~w_full | w_pop);
  assign w_drop   = w_wr_req & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_done_q   <= 1'b1;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_done_q <= rx_done;
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A new drop takes priority over a clear in the same cycle.
      if (w_drop)       r_overflow <= 1'b1;
      else if (clr_ovf) r_overflow <= 1'b0;
    end
  end

  // Storage is not reset; gating with rst keeps writes out of the reset cycle.
  always_ff @(posedge clk) begin
    if (rst && w_wr_ok) r_mem[r_wr_ptr] <= rx_data;
  end

  assign rd_valid = ~w_empty;
  assign rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign count    = r_count;
  assign full     = w_full;
  assign empty    = w_empty;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: scenario tasks with a byte scoreboard queue.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       rd_ready;
  logic       clr_ovf;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;

  logic [7:0] q[$];
  logic [7:0] exp_b;
  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data),
    .rd_ready(rd_ready), .clr_ovf(clr_ovf), .rd_valid(rd_valid),
    .rd_data(rd_data), .count(count), .full(full), .empty(empty),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0; rx_done = 1'b1; rx_data = 8'hEE; rd_ready = 1'b0; clr_ovf = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rd_valid); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", rd_data); end
    checks++; if (full !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_flags got full=%b ovf=%b exp 0 0", full, overflow); end
    rx_done = 1'b0;
    rd_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (count !== 5'd0 || rd_valid !== 1'b0) begin errors++; $display("FAIL ready_when_empty got count=%0d valid=%b exp 0 0", count, rd_valid); end
    rd_ready = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    rx_data = 8'hA5; rx_done = 1'b1; q.push_back(8'hA5);
    @(negedge clk);
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count); end
    checks++; if (rd_valid !== 1'b1 || rd_data !== q[0]) begin errors++; $display("FAIL single_data got v=%b %h exp 1 %h", rd_valid, rd_data, q[0]); end
    repeat (49) @(negedge clk);
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_once got %0d exp 1", count); end
    rx_done = 1'b0;
    @(negedge clk);
    exp_b = q.pop_front();
    checks++; if (rd_data !== exp_b) begin errors++; $display("FAIL single_pop_data got %h exp %h", rd_data, exp_b); end
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    checks++; if (empty !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL single_drained got empty=%b count=%0d exp 1 0", empty, count); end
  endtask

  task automatic test_wrap();
    int wi = 0;
    for (int c = 0; c < 120 && (wi < 24 || q.size() > 0); c++) begin
      @(negedge clk);
      checks++; if (count !== 5'(q.size()) || rd_valid !== (q.size() > 0)) begin errors++; $display("FAIL wrap_state cycle %0d got count=%0d valid=%b exp %0d %b", c, count, rd_valid, q.size(), q.size() > 0); end
      rd_ready = 1'b0;
      if (((c % 4 == 1) || wi >= 24) && q.size() > 0) begin
        exp_b = q.pop_front();
        checks++; if (rd_data !== exp_b) begin errors++; $display("FAIL wrap_data got %h exp %h", rd_data, exp_b); end
        rd_ready = 1'b1;
      end
      rx_done = 1'b0;
      if (c % 2 == 0 && wi < 24) begin
        rx_data = 8'(wi); rx_done = 1'b1; q.push_back(8'(wi)); wi++;
      end
    end
    @(negedge clk);
    rd_ready = 1'b0; rx_done = 1'b0;
    checks++; if (wi !== 24 || q.size() != 0) begin errors++; $display("FAIL wrap_done got written=%0d left=%0d exp 24 0", wi, q.size()); end
    checks++; if (overflow !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL wrap_flags got ovf=%b empty=%b exp 0 1", overflow, empty); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); rx_data = 8'h10 + 8'(i); rx_done = 1'b1; q.push_back(8'h10 + 8'(i));
      @(negedge clk); rx_done = 1'b0;
    end
    checks++; if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_fill got count=%0d full=%b ovf=%b exp 16 1 0", count, full, overflow); end
    @(negedge clk); rx_data = 8'h20; rx_done = 1'b1;
    @(negedge clk); rx_done = 1'b0;
    checks++; if (full !== 1'b1 || overflow !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL ovf_drop got full=%b ovf=%b count=%0d exp 1 1 16", full, overflow, count); end
    for (int k = 0, n = q.size(); k < n; k++) begin
      exp_b = q.pop_front();
      checks++; if (rd_valid !== 1'b1 || rd_data !== exp_b) begin errors++; $display("FAIL ovf_drain got v=%b %h exp 1 %h", rd_valid, rd_data, exp_b); end
      rd_ready = 1'b1;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    checks++; if (empty !== 1'b1 || rd_data !== 8'h00) begin errors++; $display("FAIL ovf_absent got empty=%b data=%h exp 1 00", empty, rd_data); end
    clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); rx_data = 8'h30 + 8'(i); rx_done = 1'b1; q.push_back(8'h30 + 8'(i));
      @(negedge clk); rx_done = 1'b0;
    end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL frw_fill got %0d exp 16", count); end
    @(negedge clk);
    exp_b = q.pop_front();
    checks++; if (rd_data !== exp_b) begin errors++; $display("FAIL frw_head got %h exp %h", rd_data, exp_b); end
    rd_ready = 1'b1; rx_data = 8'h55; rx_done = 1'b1; q.push_back(8'h55);
    @(negedge clk);
    rd_ready = 1'b0; rx_done = 1'b0;
    checks++; if (count !== 5'd16 || overflow !== 1'b0 || full !== 1'b1) begin errors++; $display("FAIL frw_same got count=%0d ovf=%b full=%b exp 16 0 1", count, overflow, full); end
    for (int k = 0, n = q.size(); k < n; k++) begin
      exp_b = q.pop_front();
      checks++; if (rd_valid !== 1'b1 || rd_data !== exp_b) begin errors++; $display("FAIL frw_drain got v=%b %h exp 1 %h", rd_valid, rd_data, exp_b); end
      rd_ready = 1'b1;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    checks++; if (empty !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL frw_empty got empty=%b count=%0d exp 1 0", empty, count); end
  endtask

  task automatic test_ovf_clr_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); rx_data = 8'h40 + 8'(i); rx_done = 1'b1; q.push_back(8'h40 + 8'(i));
      @(negedge clk); rx_done = 1'b0;
    end
    @(negedge clk); rx_data = 8'h99; rx_done = 1'b1;
    @(negedge clk); rx_done = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ocr_first_drop got %b exp 1", overflow); end
    @(negedge clk); rx_data = 8'h9A; rx_done = 1'b1; clr_ovf = 1'b1;
    @(negedge clk); rx_done = 1'b0; clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ocr_set_wins got %b exp 1", overflow); end
    clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ocr_clear got %b exp 0", overflow); end
    for (int k = 0; k < 9; k++) begin
      exp_b = q.pop_front();
      checks++; if (rd_data !== exp_b) begin errors++; $display("FAIL ocr_pop got %h exp %h", rd_data, exp_b); end
      rd_ready = 1'b1;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    checks++; if (count !== 5'd7 || rd_data !== q[0]) begin errors++; $display("FAIL ocr_seven got count=%0d data=%h exp 7 %h", count, rd_data, q[0]); end
    rst = 1'b0; rd_ready = 1'b1; rx_data = 8'h77; rx_done = 1'b1;
    @(negedge clk);
    rst = 1'b1; rd_ready = 1'b0;
    q.delete();
    checks++; if (count !== 5'd0 || rd_valid !== 1'b0 || empty !== 1'b1 || rd_data !== 8'h00) begin errors++; $display("FAIL ocr_reset got count=%0d valid=%b empty=%b data=%h exp 0 0 1 00", count, rd_valid, empty, rd_data); end
    repeat (3) @(negedge clk);
    rx_done = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL ocr_post_reset got %0d exp 0", count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_overflow();
    test_full_rw();
    test_ovf_clr_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
